// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU operation codes and the hard-wired zero register.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational operand forwarding mux: picks EX/MEM, then MEM/WB, then the latched
// register-file value for one source register. Register $0 is never forwarded.
module fwd_unit
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] i_reg,
  input  logic [DW-1:0] i_data,
  input  logic          i_exmem_reg_write,
  input  logic [RW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_result,
  input  logic          i_memwb_reg_write,
  input  logic [RW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_result,
  output logic [DW-1:0] o_data
);

  logic w_nonzero;
  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_nonzero   = (i_reg != RW'(REG_ZERO));
  assign w_hit_exmem = i_exmem_reg_write & (i_exmem_rd == i_reg) & w_nonzero;
  assign w_hit_memwb = i_memwb_reg_write & (i_memwb_rd == i_reg) & w_nonzero;

  // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
  always_comb begin
    o_data = i_data;
    if (w_hit_exmem)      o_data = i_exmem_result;
    else if (w_hit_memwb) o_data = i_memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Build option: define FWD_EN for forwarding muxes; without it, RAW hazards stall instead.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [3:0]    id_alu_ctrl,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [3:0]    alu_control,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  logic          r_valid;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_dest;
  logic [3:0]    r_alu_ctrl;
  logic          r_alu_src;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_mem_to_reg;

  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic          w_load_use;
  logic          w_raw_stall;

  // Stall semantics: while stall is high, ID must hold its instruction and this stage
  // loads a bubble; the held instruction is accepted on the first edge with stall low.
  assign w_load_use = r_valid & r_mem_read & (r_dest != RW'(REG_ZERO)) & id_valid &
                      ((r_dest == id_rs) | (r_dest == id_rt));
  assign stall = ~reset & (w_load_use | w_raw_stall);

  // Reset, flush and stall all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dest       <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_valid      <= id_valid;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_dest       <= id_reg_dst ? id_rd : id_rt;
      r_alu_ctrl   <= id_alu_ctrl;
      r_alu_src    <= id_alu_src;
      r_reg_write  <= id_reg_write  & id_valid;
      r_mem_read   <= id_mem_read   & id_valid;
      r_mem_write  <= id_mem_write  & id_valid;
      r_mem_to_reg <= id_mem_to_reg & id_valid;
    end
  end

`ifdef FWD_EN
  fwd_unit #(.DW(DW), .RW(RW)) u_fwd_a (
    .i_reg             (r_rs),
    .i_data            (r_rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_a)
  );

  fwd_unit #(.DW(DW), .RW(RW)) u_fwd_b (
    .i_reg             (r_rt),
    .i_data            (r_rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_b)
  );

  assign w_raw_stall = 1'b0;
`else
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_unused;

  // Without forwarding, any pending producer in EX or EX/MEM must drain before ID proceeds.
  assign w_rs_hit = (id_rs != RW'(REG_ZERO)) &
                    ((r_valid & r_reg_write & (r_dest == id_rs)) |
                     (exmem_reg_write & (exmem_rd == id_rs)));
  assign w_rt_hit = (id_rt != RW'(REG_ZERO)) &
                    ((r_valid & r_reg_write & (r_dest == id_rt)) |
                     (exmem_reg_write & (exmem_rd == id_rt)));
  assign w_raw_stall = id_valid & (w_rs_hit | w_rt_hit);

  assign w_fwd_a  = r_rs_data;
  assign w_fwd_b  = r_rt_data;
  assign w_unused = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result, r_rs, r_rt};
`endif

  assign ex_valid      = r_valid;
  assign alu_in1       = w_fwd_a;
  assign alu_in2       = r_alu_src ? r_imm : w_fwd_b;
  assign alu_control   = r_alu_ctrl;
  assign ex_store_data = w_fwd_b;
  assign ex_dest       = r_dest;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and operand-forwarding stage that feeds the ALU.
- Latches decoded operands and control from ID.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards; on one it stalls ID and inserts a bubble.
- Drives alu_in1, alu_in2 and alu_control directly into the ALU.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DW  regfile read port A
id_rt_data  in  DW  regfile read port B
id_imm  in  DW  sign-extended immediate
id_rs  in  RW  source reg A number
id_rt  in  RW  source reg B number
id_rd  in  RW  R-type destination
id_alu_ctrl  in  4  ALU operation code
id_alu_src  in  1  1 = operand B is immediate
id_reg_dst  in  1  1 = destination is rd, 0 = rt
id_reg_write  in  1  ID control: register write
id_mem_read  in  1  ID control: memory read
id_mem_write  in  1  ID control: memory write
id_mem_to_reg  in  1  ID control: writeback from memory
flush  in  1  kill the instruction entering EX (taken branch)
exmem_reg_write  in  1  EX/MEM writes a register
exmem_rd  in  RW  EX/MEM destination
exmem_result  in  DW  EX/MEM ALU result
memwb_reg_write  in  1  MEM/WB writes a register
memwb_rd  in  RW  MEM/WB destination
memwb_result  in  DW  MEM/WB writeback value
stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  EX holds a real instruction
alu_in1  out  DW  ALU operand A
alu_in2  out  DW  ALU operand B
alu_control  out  4  ALU operation code
ex_store_data  out  DW  forwarded rt value for sw
ex_dest  out  RW  resolved destination register
ex_reg_write  out  1  EX control: register write
ex_mem_read  out  1  EX control: memory read
ex_mem_write  out  1  EX control: memory write
ex_mem_to_reg  out  1  EX control: writeback from memory

Behaviour:
- Reset: every registered field clears to 0, so ex_valid=0, all ex_* controls=0, alu_control=4'b0000, ex_dest=0. stall=0 while reset is high.
- Each clock edge loads exactly one of three things, in priority order:
  - reset: clear, as above.
  - flush or stall: load a bubble. Valid and all four control bits go to 0; data fields are don't-care but are zeroed.
  - otherwise: load the ID fields, with valid = id_valid, dest = id_reg_dst ? id_rd : id_rt, and controls gated by id_valid.
- Latency: one cycle from ID to ALU inputs. Forwarding muxes are combinational on the registered values.
- Load-use hazard: stall = ex_valid & ex_mem_read & (ex_dest != 0) & id_valid & ((ex_dest == id_rs) | (ex_dest == id_rt)).
  - The id_rt match applies regardless of id_alu_src.
  - Stall is exactly one cycle per hazard.
  - Flush and stall together: flush wins the register load; stall is still reported.
- Forwarding of operand A (register rs_q):
  - If exmem_reg_write and exmem_rd == rs_q and rs_q != 0, use exmem_result.
  - Else if memwb_reg_write and memwb_rd == rs_q and rs_q != 0, use memwb_result.
  - Else use the latched rs data.
  - When both EX/MEM and MEM/WB match, EX/MEM wins.
- Forwarding of operand B: same rules on rt_q, giving fwd_b.
  - ex_store_data = fwd_b.
  - alu_in2 = alu_src_q ? imm_q : fwd_b.
- Register $0 is never forwarded.
- alu_control passes id_alu_ctrl through untouched. Valid codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- The register file writes before it reads, so a MEM/WB-to-ID hazard needs no handling here.

Optional Feature:
FWD_EN
- Defined: forwarding muxes as above.
- Undefined:
  - Muxes are removed; alu_in1 and fwd_b are the raw latched values.
  - stall also asserts when id_valid and a nonzero id_rs or id_rt matches either of:
    - ex_dest with ex_reg_write & ex_valid
    - exmem_rd with exmem_reg_write
  - Bubbles and priority are unchanged.

Decomposition:
- Shared package holds:
  - ALU code constants: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_SLT=4'b0111, ALU_NOR=4'b1100.
  - REG_ZERO = 5'd0.
- Sub-module fwd_unit: purely combinational.
  - Inputs: register number, latched data, exmem/memwb tuples.
  - Output: forwarded value.
  - Instantiated twice, once per operand.

Test Plan:
- Reset: assert reset for 2 cycles with id_valid=1 -> all outputs 0 and stall=0; the first edge after release loads the ID fields.
- EX/MEM forward: latch rs=3 (rs_data=5); exmem_reg_write=1, exmem_rd=3, exmem_result=42; memwb also writes rd=3 with 7 -> alu_in1=42.
- MEM/WB forward and $0 guard:
  - rt=4, memwb_rd=4, memwb_result=9, alu_src=0 -> alu_in2=9 and ex_store_data=9.
  - With rs=0 and exmem_rd=0 -> alu_in1=rs_data.
- Load-use: lw into $2 in EX, next ID uses rs=2 -> stall=1 for exactly one cycle; the following cycle ex_valid=0 and ex_reg_write=0; the cycle after that the dependent instruction enters EX.
- Flush: flush=1 with id_valid=1, id_reg_write=1, id_mem_write=1 -> next cycle ex_valid=0 and all ex_* controls 0; flush+stall together -> a bubble is loaded.
- Immediate: alu_src=1, imm=32'hFFFF_FFFC, alu_ctrl=ALU_ADD -> alu_in2=32'hFFFF_FFFC and alu_control=4'b0010. With FWD_EN undefined, a RAW on ex_dest -> stall=1.
